// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the multi-precision byte-serial adder/subtractor.
package mp_add_seq_pkg;

    // Sequencer states: wait for a request, one byte pass per cycle, result pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the byte index for a given byte count. It is at least one bit,
    // so the index register never collapses to zero width.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/mp_add_seq_byte_adder.sv
// Plain 8-bit ripple-carry adder. This is the shared arithmetic unit that the
// sequencer feeds one operand byte per cycle.
module byte_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    logic [8:0] c;

    // Full-adder chain, bit 0 first.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        co = c[8];
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder/subtractor. One 8*NBYTES-bit add or subtract is done
// as NBYTES passes through one 8-bit adder, least significant byte first, with
// the carry held in a register between passes. Subtraction is a + ~b + 1, so
// the final carry-out is 1 when no borrow occurred (a >= b unsigned).
//
// Handshake: a request is taken on any rising edge where start=1 while the
// sequencer is not busy (IDLE or the DONE cycle). The result (sum, ovf) is
// valid in the cycle where done=1 and holds until the next request is taken.
// There is no back-pressure; start while busy is dropped, not queued.
module mp_add_seq
    import mp_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES:0]   sum,
    output logic                ovf,
    output state_e              state_dbg
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = idx_width(NBYTES);

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            sub_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W:0]      sum_q;
    logic            busy_q;
    logic            done_q;
    logic            ovf_q;

    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      add_s;
    logic            add_co;
    logic            last_pass;
    logic            ovf_d;

    // Select the operand bytes for the current pass; B is inverted when subtracting.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) begin
                a_byte = a_q[8*i +: 8];
                b_byte = b_q[8*i +: 8] ^ {8{sub_q}};
            end
        end
    end

    byte_adder u_byte_adder (
        .a  (a_byte),
        .b  (b_byte),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    // Overflow: operands of equal sign (after the subtract inversion) producing
    // a result of the other sign. Only meaningful on the last pass.
    always_comb begin
        last_pass = (idx_q == IW'(NBYTES - 1));
        ovf_d     = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (add_s[7] != a_q[W-1]);
    end

    // Sequencer: request capture, byte passes, carry chaining and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        carry_q <= sub;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx_q == IW'(i)) begin
                            sum_q[8*i +: 8] <= add_s;
                        end
                    end
                    carry_q <= add_co;
                    idx_q   <= idx_q + 1'b1;
                    if (last_pass) begin
                        sum_q[W] <= add_co;
                        ovf_q    <= ovf_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq with NBYTES=4: directed and random operations compared
// against an arithmetic reference model.
module tb_mp_add_seq;
    import mp_add_seq_pkg::*;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           sub;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [W:0]     sum;
    logic           ovf;
    state_e         state_dbg;

    int checks = 0;
    int errors = 0;

    mp_add_seq #(.NBYTES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference model: plain W-bit arithmetic.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rs);
        logic [W-1:0] diff;
        if (!rs) return {1'b0, ra} + {1'b0, rb};
        diff = ra - rb;
        return {(ra >= rb), diff};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                     input logic rs);
        longint sa, sb, r;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        r  = rs ? (sa - sb) : (sa + sb);
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // Scoreboard comparison
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver: one full operation, checking busy and partial sums every RUN
    // cycle, then the result, then that it holds one cycle later. With poke
    // set, start is pulsed with other operands during RUN cycles 2 and 3.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input bit poke, input string tag);
        logic [W:0] es;
        logic [W:0] one;
        logic [W:0] mask;
        logic       eo;
        int         cyc;
        es  = ref_sum(ta, tb_v, ts);
        eo  = ref_ovf(ta, tb_v, ts);
        one = 1;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; sub = ts;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 3 * N) begin
            chk({tag, " busy"}, 64'(busy), 64'(1));
            mask = (one << (8 * (cyc - 1))) - one;
            chk({tag, " partial"}, 64'(sum), 64'(es & mask));
            if (poke && (cyc == 2 || cyc == 3)) begin
                start = 1'b1; a = $urandom; b = $urandom; sub = ~ts;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(cyc), 64'(N + 1));
        chk({tag, " done"}, 64'(done), 64'(1));
        chk({tag, " busy@done"}, 64'(busy), 64'(0));
        chk({tag, " sum"}, 64'(sum), 64'(es));
        chk({tag, " ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        chk({tag, " done pulse"}, 64'(done), 64'(0));
        chk({tag, " sum hold"}, 64'(sum), 64'(es));
        chk({tag, " ovf hold"}, 64'(ovf), 64'(eo));
    endtask

    initial begin
        logic [W-1:0] ra, rb, ra2, rb2;
        logic         rs, rs2;
        int           cyc;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #3;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset sum", 64'(sum), 64'(0));
        chk("reset ovf", 64'(ovf), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, "add carry b0->b1");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, "add carry out");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "add ovf");
        run_op(32'd5, 32'd3, 1'b1, 1'b0, "sub no borrow");
        run_op(32'd3, 32'd5, 1'b1, 1'b0, "sub borrow");
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, "sub ovf");
        run_op(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b1, "start ignored");

        // Back-to-back: second request in the DONE cycle of the first
        ra = $urandom; rb = $urandom; rs = 1'b0;
        ra2 = $urandom; rb2 = $urandom; rs2 = 1'b1;
        @(negedge clk);
        start = 1'b1; a = ra; b = rb; sub = rs;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 3 * N) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b first done", 64'(done), 64'(1));
        chk("b2b first sum", 64'(sum), 64'(ref_sum(ra, rb, rs)));
        start = 1'b1; a = ra2; b = rb2; sub = rs2;
        @(negedge clk);
        start = 1'b0;
        chk("b2b busy", 64'(busy), 64'(1));
        chk("b2b done low", 64'(done), 64'(0));
        chk("b2b sum cleared", 64'(sum), 64'(0));
        cyc = 1;
        while (!done && cyc < 3 * N) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b spacing", 64'(cyc), 64'(N + 1));
        chk("b2b second sum", 64'(sum), 64'(ref_sum(ra2, rb2, rs2)));
        chk("b2b second ovf", 64'(ovf), 64'(ref_ovf(ra2, rb2, rs2)));

        // Reset mid-operation aborts asynchronously
        @(negedge clk);
        start = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort sum", 64'(sum), 64'(0));
        chk("abort ovf", 64'(ovf), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 2) begin
            @(negedge clk);
            chk("no done after abort", 64'(done), 64'(0));
        end
        run_op(32'hDEADBEEF, 32'h21524111, 1'b0, 1'b0, "after reset");

        // Random operations, including edge operand values
        for (int k = 0; k < 12; k++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: rb = ra;
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, 1'($urandom_range(0, 1)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed no finish, required finish before limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
